// File: rtl/cam_pkg.sv
// Shared types, encodings and pixel conversion helpers for the camera frame writer.
package cam_pkg;

  localparam int unsigned FMT_RGB565 = 0;
  localparam int unsigned FMT_RGB444 = 1;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_FRAME = 2'd2
  } cam_state_e;

  // byte0 = R[4:0]G[5:3], byte1 = G[2:0]B[4:0] -> {R[4:2], G[5:3], B[4:3]}
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[7:5], b0[2:0], b1[4:3]};
  endfunction

  // byte0 = xxxx R[3:0], byte1 = G[3:0] B[3:0] -> {R[3:1], G[3:1], B[3:2]}
  function automatic logic [7:0] rgb444_to_332(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[3:1], b1[7:5], b1[3:2]};
  endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// Byte-pair assembler: tracks the byte phase within HREF and emits one RGB332 pixel per pair.
module cam_pixel_pack
  import cam_pkg::*;
#(
  parameter int unsigned FMT = FMT_RGB565
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_href,
  input  logic [7:0] i_d,
  output logic       o_pix_valid,
  output logic [7:0] o_pix_data
);

  logic       r_phase;
  logic [7:0] r_byte0;
  logic       r_pix_valid;
  logic [7:0] r_pix_data;
  logic [7:0] w_conv;

  assign w_conv = (FMT == FMT_RGB444) ? rgb444_to_332(r_byte0, i_d)
                                      : rgb565_to_332(r_byte0, i_d);

  // A dangling byte0 is simply dropped when HREF falls and the phase clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= 1'b0;
      r_byte0     <= 8'd0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= 8'd0;
    end else begin
      r_pix_valid <= 1'b0;
      if (!i_href) begin
        r_phase <= 1'b0;
      end else begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_byte0 <= i_d;
        end else begin
          r_pix_valid <= 1'b1;
          r_pix_data  <= w_conv;
        end
      end
    end
  end

  assign o_pix_valid = r_pix_valid;
  assign o_pix_data  = r_pix_data;

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-bus to frame-buffer write engine: frame FSM, decimation, linear addressing and line checks.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH  = 176,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned FMT    = FMT_RGB565,
  parameter int unsigned DECIM  = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic              FREEZE,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic              LINE_ERR,
  output logic [7:0]        LINE_CNT
);

  localparam int unsigned    SH         = (DECIM == 4) ? 2 : (DECIM == 2) ? 1 : 0;
  localparam logic [CNT_W-1:0] MASK       = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0] LINE_BYTES = CNT_W'(2 * WIDTH * DECIM);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  cam_state_e r_state, w_state_next;

  logic              r_vs_q, r_href_q, r_vs_d1, r_href_d1;
  logic [7:0]        r_d_q;
  logic              r_frz, r_err;
  logic [CNT_W-1:0]  r_px, r_ln, r_bcnt;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_w_en, r_frame_done, r_line_err;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_data, r_line_cnt;

  logic              w_pix_valid;
  logic [7:0]        w_pix_data;
  logic              w_frame_start, w_frame_end;
  logic              w_vs_rise, w_vs_fall, w_href_fall;
  logic              w_line_end, w_bad_line, w_wr_ok, w_row_adv, w_err_next;
  logic [CNT_W-1:0]  w_x, w_y, w_bytes, w_ln_next;

  cam_pixel_pack #(.FMT(FMT)) u_pack (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_href      (r_href_q),
    .i_d         (r_d_q),
    .o_pix_valid (w_pix_valid),
    .o_pix_data  (w_pix_data)
  );

  assign w_vs_rise   = r_vs_q & ~r_vs_d1;
  assign w_vs_fall   = ~r_vs_q & r_vs_d1;
  assign w_href_fall = ~r_href_q & r_href_d1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE:  if (r_vs_q) w_state_next = S_SYNC;
      S_SYNC:  if (w_vs_fall) begin
                 w_state_next  = S_FRAME;
                 w_frame_start = 1'b1;
               end
      S_FRAME: if (w_vs_rise) begin
                 w_state_next = S_SYNC;
                 w_frame_end  = 1'b1;
               end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A VSYNC rise in the middle of a line closes that line before the frame ends.
  assign w_line_end = (r_state == S_FRAME) &&
                      (w_href_fall || (w_vs_rise && (r_href_q || (r_bcnt != '0))));
  assign w_bytes    = r_bcnt + CNT_W'(r_href_q);
  assign w_bad_line = (w_bytes != LINE_BYTES) || w_bytes[0];
  assign w_err_next = r_err | (w_line_end & w_bad_line);
  assign w_ln_next  = (w_line_end && (r_ln != CNT_MAX)) ? r_ln + CNT_W'(1) : r_ln;
  assign w_row_adv  = ((w_ln_next & MASK) == '0) && ((w_ln_next >> SH) < CNT_W'(HEIGHT));

  assign w_x     = r_px >> SH;
  assign w_y     = r_ln >> SH;
  assign w_wr_ok = w_pix_valid && (r_state == S_FRAME) && !r_frz &&
                   ((r_px & MASK) == '0) && ((r_ln & MASK) == '0) &&
                   (w_x < CNT_W'(WIDTH)) && (w_y < CNT_W'(HEIGHT));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs_q       <= 1'b0;
      r_href_q     <= 1'b0;
      r_d_q        <= 8'd0;
      r_vs_d1      <= 1'b0;
      r_href_d1    <= 1'b0;
      r_frz        <= 1'b0;
      r_err        <= 1'b0;
      r_px         <= '0;
      r_ln         <= '0;
      r_bcnt       <= '0;
      r_row_base   <= '0;
      r_w_en       <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= 8'd0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_line_cnt   <= 8'd0;
    end else begin
      r_vs_q       <= VSYNC;
      r_href_q     <= HREF;
      r_d_q        <= D;
      r_vs_d1      <= r_vs_q;
      r_href_d1    <= r_href_q;
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_frame_start) begin
        r_frz      <= FREEZE;
        r_err      <= 1'b0;
        r_px       <= '0;
        r_ln       <= '0;
        r_bcnt     <= '0;
        r_row_base <= '0;
      end else if (r_state == S_FRAME) begin
        if (r_href_q && (r_bcnt != CNT_MAX)) r_bcnt <= r_bcnt + CNT_W'(1);
        if (w_pix_valid && (r_px != CNT_MAX)) r_px <= r_px + CNT_W'(1);
        if (w_wr_ok) begin
          r_w_en   <= 1'b1;
          r_w_addr <= r_row_base + ADDR_W'(w_x);
          r_w_data <= w_pix_data;
        end
        // Line end overrides the per-byte/per-pixel increments above.
        if (w_line_end) begin
          r_px   <= '0;
          r_bcnt <= '0;
          r_ln   <= w_ln_next;
          r_err  <= w_err_next;
          if (w_row_adv) r_row_base <= r_row_base + ADDR_W'(WIDTH);
        end
        if (w_frame_end) begin
          r_frame_done <= 1'b1;
          r_line_err   <= w_err_next;
          r_line_cnt   <= (w_ln_next > CNT_W'(255)) ? 8'hFF : w_ln_next[7:0];
        end
      end
    end
  end

  assign W_EN       = r_w_en;
  assign W_ADDR     = r_w_addr;
  assign W_DATA     = r_w_data;
  assign FRAME_DONE = r_frame_done;
  assign LINE_ERR   = r_line_err;
  assign LINE_CNT   = r_line_cnt;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer: two parameter sets driven by one camera bus, per-line reference model.
module tb_cam_frame_writer;

  localparam int W0 = 176, H0 = 144, D0 = 1, F0 = 0;
  localparam int W1 = 4,   H1 = 2,   D1 = 2, F1 = 1;

  logic        CLK = 1'b0;
  logic        RESET_N, VSYNC, HREF, FREEZE;
  logic [7:0]  D;

  logic        w_en0, done0, lerr0, w_en1, done1, lerr1;
  logic [14:0] w_addr0;
  logic [2:0]  w_addr1;
  logic [7:0]  w_data0, cnt0, w_data1, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned qa0[$], qd0[$], qc0[$], qe0[$];
  int unsigned qa1[$], qd1[$], qc1[$], qe1[$];
  logic [7:0]  line_q[$];
  bit          cur_frz, ferr0, ferr1;

  always #5 CLK = ~CLK;

  cam_frame_writer u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF), .D(D), .FREEZE(FREEZE),
    .W_EN(w_en0), .W_ADDR(w_addr0), .W_DATA(w_data0),
    .FRAME_DONE(done0), .LINE_ERR(lerr0), .LINE_CNT(cnt0)
  );

  cam_frame_writer #(.WIDTH(W1), .HEIGHT(H1), .ADDR_W(3), .FMT(F1), .DECIM(D1)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF), .D(D), .FREEZE(FREEZE),
    .W_EN(w_en1), .W_ADDR(w_addr1), .W_DATA(w_data1),
    .FRAME_DONE(done1), .LINE_ERR(lerr1), .LINE_CNT(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Colour conversion from the channel definitions: extract R/G/B, keep the top bits.
  function automatic int unsigned conv(input int f, input int unsigned b0, input int unsigned b1);
    int unsigned r, g, b;
    if (f == 0) begin
      r = b0 / 8; g = (b0 % 8) * 8 + b1 / 32; b = b1 % 32;
      return (r / 4) * 32 + (g / 8) * 4 + (b / 8);
    end
    r = b0 % 16; g = b1 / 16; b = b1 % 16;
    return (r / 2) * 32 + (g / 2) * 4 + (b / 4);
  endfunction

  task automatic model_line(input int k, input int l);
    int w, h, d, f, np;
    int unsigned a, v;
    w = (k == 0) ? W0 : W1;
    h = (k == 0) ? H0 : H1;
    d = (k == 0) ? D0 : D1;
    f = (k == 0) ? F0 : F1;
    np = line_q.size() / 2;
    for (int p = 0; p < np; p++) begin
      if (!cur_frz && (p % d == 0) && (l % d == 0) && (p / d < w) && (l / d < h)) begin
        a = (l / d) * w + p / d;
        v = conv(f, line_q[2*p], line_q[2*p+1]);
        if (k == 0) begin qa0.push_back(a); qd0.push_back(v); end
        else        begin qa1.push_back(a); qd1.push_back(v); end
      end
    end
    if (line_q.size() != 2 * w * d) begin
      if (k == 0) ferr0 = 1'b1; else ferr1 = 1'b1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen0"},  32'(w_en0),   0);
    check({tag, "_addr0"}, 32'(w_addr0), 0);
    check({tag, "_data0"}, 32'(w_data0), 0);
    check({tag, "_done0"}, 32'(done0),   0);
    check({tag, "_lerr0"}, 32'(lerr0),   0);
    check({tag, "_cnt0"},  32'(cnt0),    0);
    check({tag, "_wen1"},  32'(w_en1),   0);
    check({tag, "_cnt1"},  32'(cnt1),    0);
  endtask

  // pat 0: random bytes; pat 1: alternating directed colour pairs.
  task automatic send_frame(input int nlines, input int len, input int bad_line, input bit frz,
                            input int drop_line, input int rst_line, input int pat);
    bit aborted = 1'b0;
    int n;
    ferr0 = 1'b0; ferr1 = 1'b0; cur_frz = frz;
    FREEZE = frz; VSYNC = 1'b0; HREF = 1'b0;
    tick(4);
    for (int l = 0; l < nlines; l++) begin
      if (l == drop_line) FREEZE = 1'b0;
      if (l == rst_line) begin
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick(3);
        RESET_N = 1'b1;
        aborted = 1'b1;
      end
      n = (l == bad_line) ? len - 1 : len;
      line_q.delete();
      for (int i = 0; i < n; i++) begin
        if (pat == 1) begin
          case (i % 4)
            0: line_q.push_back(8'hF8);
            1: line_q.push_back(8'h1F);
            2: line_q.push_back(8'h0F);
            default: line_q.push_back(8'hF0);
          endcase
        end else begin
          line_q.push_back(8'($urandom_range(0, 255)));
        end
      end
      if (!aborted) begin model_line(0, l); model_line(1, l); end
      foreach (line_q[i]) begin HREF = 1'b1; D = line_q[i]; tick(1); end
      HREF = 1'b0;
      tick(4);
    end
    VSYNC = 1'b1;
    if (!aborted) begin
      qc0.push_back((nlines > 255) ? 255 : nlines); qe0.push_back(32'(ferr0));
      qc1.push_back((nlines > 255) ? 255 : nlines); qe1.push_back(32'(ferr1));
    end
    tick(10);
    check("pending_wr0",   32'(qa0.size()), 0);
    check("pending_wr1",   32'(qa1.size()), 0);
    check("pending_done0", 32'(qc0.size()), 0);
    check("pending_done1", 32'(qc1.size()), 0);
  endtask

  always @(negedge CLK) begin
    if (w_en0) begin
      if (qa0.size() == 0) check("wr0_unexpected", 32'(w_en0), 0);
      else begin
        check("wr0_addr", 32'(w_addr0), qa0.pop_front());
        check("wr0_data", 32'(w_data0), qd0.pop_front());
      end
    end
    if (done0) begin
      if (qc0.size() == 0) check("done0_unexpected", 32'(done0), 0);
      else begin
        check("line_cnt0", 32'(cnt0), qc0.pop_front());
        check("line_err0", 32'(lerr0), qe0.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (w_en1) begin
      if (qa1.size() == 0) check("wr1_unexpected", 32'(w_en1), 0);
      else begin
        check("wr1_addr", 32'(w_addr1), qa1.pop_front());
        check("wr1_data", 32'(w_data1), qd1.pop_front());
      end
    end
    if (done1) begin
      if (qc1.size() == 0) check("done1_unexpected", 32'(done1), 0);
      else begin
        check("line_cnt1", 32'(cnt1), qc1.pop_front());
        check("line_err1", 32'(lerr1), qe1.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N = 1'b0; VSYNC = 1'b1; HREF = 1'b0; D = 8'd0; FREEZE = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    tick(5);

    send_frame(144, 352, -1, 1'b0, -1, -1, 0);  // full default frame
    send_frame(4,   16,  -1, 1'b0, -1, -1, 1);  // decimation frame, directed colours
    send_frame(3,   352,  1, 1'b0, -1, -1, 0);  // one 351-byte line
    send_frame(3,   352, -1, 1'b0, -1, -1, 0);  // clean again
    send_frame(3,   16,  -1, 1'b1, -1, -1, 0);  // frozen
    send_frame(4,   16,  -1, 1'b1,  1, -1, 0);  // freeze dropped mid-frame
    send_frame(52,  16,  -1, 1'b0, -1, 50, 0);  // reset at line 50
    send_frame(4,   16,  -1, 1'b0, -1, -1, 0);  // restart from address 0
    send_frame(260, 2,   -1, 1'b0, -1, -1, 0);  // line count saturation

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
